// File: rtl/pwr_seq_pkg.sv
// Shared constants for the board power/reset sequencer: state encodings,
// latched fault causes and small state-class helpers.
package pwr_seq_pkg;

   // State encodings are visible on the state output and must stay fixed.
   localparam logic [3:0] ST_OFF     = 4'd0;
   localparam logic [3:0] ST_WAIT_ATX = 4'd1;
   localparam logic [3:0] ST_EN_1V5  = 4'd2;
   localparam logic [3:0] ST_EN_1V8  = 4'd3;
   localparam logic [3:0] ST_EN_0V95 = 4'd4;
   localparam logic [3:0] ST_WAIT_PG = 4'd5;
   localparam logic [3:0] ST_CLK_ON  = 4'd6;
   localparam logic [3:0] ST_RST1    = 4'd7;
   localparam logic [3:0] ST_ON      = 4'd8;
   localparam logic [3:0] ST_SD_RST  = 4'd9;
   localparam logic [3:0] ST_SD_0V95 = 4'd10;
   localparam logic [3:0] ST_SD_1V8  = 4'd11;
   localparam logic [3:0] ST_SD_1V5  = 4'd12;
   localparam logic [3:0] ST_FAULT   = 4'd15;

   // Latched fault causes.
   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_ATX_LOST = 3'd1;
   localparam logic [2:0] FC_PG_TMO   = 3'd2;
   localparam logic [2:0] FC_PG_LOST  = 3'd3;

   // States in which ATX loss and shutdown requests are supervised.
   function automatic logic in_run(input logic [3:0] st);
      return (st >= ST_EN_1V5) && (st <= ST_ON);
   endfunction

   // States in which PMIC/PEX power-good must stay asserted.
   function automatic logic in_clk_phase(input logic [3:0] st);
      return (st >= ST_CLK_ON) && (st <= ST_ON);
   endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// Board-side signal bundle of the power sequencer. The slave modport is the
// sequencer itself; the master modport is whatever drives the request and
// power-good inputs (board top level or a testbench).
interface pwr_seq_ctrl_if;
   logic       pwr_req;
   logic       fault_clr;
   logic       atx_pgood;
   logic       pmic_pgood;
   logic       pex_pgood;
   logic       en_1v5;
   logic       en_1v8;
   logic       en_0v95;
   logic       clk_pwrgd;
   logic       refclk_oe;
   logic       cpu_reset_n;
   logic       pex_perst_n;
   logic       sys_reset_n;
   logic       slot_perst_n;
   logic [3:0] state;
   logic       fault;
   logic [2:0] fault_code;

   modport master (
      output pwr_req, fault_clr, atx_pgood, pmic_pgood, pex_pgood,
      input  en_1v5, en_1v8, en_0v95, clk_pwrgd, refclk_oe,
             cpu_reset_n, pex_perst_n, sys_reset_n, slot_perst_n,
             state, fault, fault_code
   );

   modport slave (
      input  pwr_req, fault_clr, atx_pgood, pmic_pgood, pex_pgood,
      output en_1v5, en_1v8, en_0v95, clk_pwrgd, refclk_oe,
             cpu_reset_n, pex_perst_n, sys_reset_n, slot_perst_n,
             state, fault, fault_code
   );
endinterface

// File: rtl/pwr_seq_timer.sv
// Dwell/timeout timer: a TICK_DIV prescaler feeding a tick counter. Both are
// zeroed by clr, so a target of N ticks completes exactly N*TICK_DIV clocks
// after the clr cycle.
module pwr_seq_timer #(
   parameter int TICK_DIV = 100,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] target,
   output logic             done
);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0] pre_q;
   logic [CNT_W-1:0] tick_q;
   logic             tick_end;

   assign tick_end = (pre_q == PRE_W'(TICK_DIV - 1));

   // done is raised in the last clock of the target-th tick so that the FSM
   // leaves the state on the edge that completes the dwell.
   assign done = tick_end && (tick_q == (target - CNT_W'(1)));

   // Prescaler and saturating tick counter, restarted on every state entry.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pre_q  <= '0;
         tick_q <= '0;
      end else if (tick_end) begin
         pre_q <= '0;
         if (tick_q != {CNT_W{1'b1}}) begin
            tick_q <= tick_q + CNT_W'(1);
         end
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Board power and reset sequencer: rails 1V5 -> 1V8 -> 0V95, power-good
// check, clocks, then staged reset release; reverse-order shutdown and a
// latched fault on supervision failure.
module pwr_seq_ctrl
   import pwr_seq_pkg::*;
#(
   parameter int TICK_DIV  = 100,
   parameter int RAIL_DLY  = 1000,
   parameter int PGOOD_TMO = 50000,
   parameter int RST_DLY   = 2000,
   parameter int CNT_W     = 16
) (
   input logic           clk,
   input logic           rst,
   pwr_seq_ctrl_if.slave bus
);

   logic [3:0]       state_q, state_d;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic             tmr_clr, tmr_done;
   logic [CNT_W-1:0] tmr_target;
   logic             pg_both;

   logic en_1v5_q, en_1v5_d;
   logic en_1v8_q, en_1v8_d;
   logic en_0v95_q, en_0v95_d;
   logic clk_on_d, rst1_d, on_d;
   logic clk_pwrgd_q, refclk_oe_q;
   logic cpu_reset_n_q, pex_perst_n_q, sys_reset_n_q, slot_perst_n_q;

   assign pg_both = bus.pmic_pgood & bus.pex_pgood;

   // Dwell length (or timeout) that applies to the current state.
   always_comb begin
      tmr_target = CNT_W'(RAIL_DLY);
      case (state_q)
         ST_WAIT_PG:                      tmr_target = CNT_W'(PGOOD_TMO);
         ST_CLK_ON, ST_RST1, ST_SD_RST:   tmr_target = CNT_W'(RST_DLY);
         default:                         tmr_target = CNT_W'(RAIL_DLY);
      endcase
   end

   // Timer restarts whenever the FSM is about to change state.
   assign tmr_clr = (state_d != state_q);

   pwr_seq_timer #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .target (tmr_target),
      .done   (tmr_done)
   );

   // Next-state logic. Within the supervised states, faults outrank a
   // shutdown request, which outranks normal progression; in WAIT_PG a
   // simultaneous power-good beats the timeout.
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      code_d  = code_q;
      if (in_run(state_q)) begin
         if (!bus.atx_pgood) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_ATX_LOST;
         end else if (in_clk_phase(state_q) && !pg_both) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_PG_LOST;
         end else if ((state_q == ST_WAIT_PG) && tmr_done && !pg_both) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_PG_TMO;
         end else if (!bus.pwr_req) begin
            state_d = ST_SD_RST;
         end else begin
            case (state_q)
               ST_EN_1V5:  if (tmr_done) state_d = ST_EN_1V8;
               ST_EN_1V8:  if (tmr_done) state_d = ST_EN_0V95;
               ST_EN_0V95: if (tmr_done) state_d = ST_WAIT_PG;
               ST_WAIT_PG: if (pg_both)  state_d = ST_CLK_ON;
               ST_CLK_ON:  if (tmr_done) state_d = ST_RST1;
               ST_RST1:    if (tmr_done) state_d = ST_ON;
               default:    state_d = state_q;
            endcase
         end
      end else begin
         case (state_q)
            ST_OFF: begin
               if (bus.pwr_req) state_d = ST_WAIT_ATX;
            end
            ST_WAIT_ATX: begin
               if (!bus.pwr_req)       state_d = ST_OFF;
               else if (bus.atx_pgood) state_d = ST_EN_1V5;
            end
            ST_SD_RST:  if (tmr_done) state_d = ST_SD_0V95;
            ST_SD_0V95: if (tmr_done) state_d = ST_SD_1V8;
            ST_SD_1V8:  if (tmr_done) state_d = ST_SD_1V5;
            ST_SD_1V5:  if (tmr_done) state_d = ST_OFF;
            ST_FAULT: begin
               if (bus.fault_clr && !bus.pwr_req) begin
                  state_d = ST_OFF;
                  fault_d = 1'b0;
                  code_d  = FC_NONE;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // State and latched fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         code_q  <= code_d;
      end
   end

   // Output decode from the state register. During shutdown the rails hold
   // whatever they were, except the one being dropped in that step.
   always_comb begin
      en_1v5_d  = 1'b0;
      en_1v8_d  = 1'b0;
      en_0v95_d = 1'b0;
      clk_on_d  = 1'b0;
      rst1_d    = 1'b0;
      on_d      = 1'b0;
      case (state_q)
         ST_EN_1V5: en_1v5_d = 1'b1;
         ST_EN_1V8: begin
            en_1v5_d = 1'b1;
            en_1v8_d = 1'b1;
         end
         ST_EN_0V95, ST_WAIT_PG, ST_CLK_ON, ST_RST1, ST_ON: begin
            en_1v5_d  = 1'b1;
            en_1v8_d  = 1'b1;
            en_0v95_d = 1'b1;
            clk_on_d  = (state_q == ST_CLK_ON) || (state_q == ST_RST1) ||
                        (state_q == ST_ON);
            rst1_d    = (state_q == ST_RST1) || (state_q == ST_ON);
            on_d      = (state_q == ST_ON);
         end
         ST_SD_RST: begin
            en_1v5_d  = en_1v5_q;
            en_1v8_d  = en_1v8_q;
            en_0v95_d = en_0v95_q;
         end
         ST_SD_0V95: begin
            en_1v5_d = en_1v5_q;
            en_1v8_d = en_1v8_q;
         end
         ST_SD_1V8: en_1v5_d = en_1v5_q;
         default: en_1v5_d = 1'b0;
      endcase
   end

   // Output registers; everything lands one clock after the state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_1v5_q       <= 1'b0;
         en_1v8_q       <= 1'b0;
         en_0v95_q      <= 1'b0;
         clk_pwrgd_q    <= 1'b0;
         refclk_oe_q    <= 1'b0;
         cpu_reset_n_q  <= 1'b0;
         pex_perst_n_q  <= 1'b0;
         sys_reset_n_q  <= 1'b0;
         slot_perst_n_q <= 1'b0;
      end else begin
         en_1v5_q       <= en_1v5_d;
         en_1v8_q       <= en_1v8_d;
         en_0v95_q      <= en_0v95_d;
         clk_pwrgd_q    <= clk_on_d;
         refclk_oe_q    <= clk_on_d;
         cpu_reset_n_q  <= rst1_d;
         pex_perst_n_q  <= rst1_d;
         sys_reset_n_q  <= on_d;
         slot_perst_n_q <= on_d;
      end
   end

   assign bus.en_1v5       = en_1v5_q;
   assign bus.en_1v8       = en_1v8_q;
   assign bus.en_0v95      = en_0v95_q;
   assign bus.clk_pwrgd    = clk_pwrgd_q;
   assign bus.refclk_oe    = refclk_oe_q;
   assign bus.cpu_reset_n  = cpu_reset_n_q;
   assign bus.pex_perst_n  = pex_perst_n_q;
   assign bus.sys_reset_n  = sys_reset_n_q;
   assign bus.slot_perst_n = slot_perst_n_q;
   assign bus.state        = state_q;
   assign bus.fault        = fault_q;
   assign bus.fault_code   = code_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Scoreboard bench for pwr_seq_ctrl. Each stimulus step pushes the expected
// sequence of output snapshots (state, all outputs, fault, code) together with
// the clock distance from the previous change or stimulus; a monitor compares
// every observed change against the head of the queue.
module tb_pwr_seq_ctrl;

   localparam int TICK_DIV  = 4;
   localparam int RAIL_DLY  = 3;
   localparam int PGOOD_TMO = 10;
   localparam int RST_DLY   = 2;

   // {en_1v5, en_1v8, en_0v95, clk_pwrgd, refclk_oe,
   //  cpu_reset_n, pex_perst_n, sys_reset_n, slot_perst_n}
   localparam logic [8:0] O_NONE  = 9'b000000000;
   localparam logic [8:0] O_15    = 9'b100000000;
   localparam logic [8:0] O_18    = 9'b110000000;
   localparam logic [8:0] O_RAILS = 9'b111000000;
   localparam logic [8:0] O_CLK   = 9'b111110000;
   localparam logic [8:0] O_RST1  = 9'b111111100;
   localparam logic [8:0] O_ON    = 9'b111111111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   mark_cyc = 0;
   int   last_chg = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   logic [16:0] exp_q[$];
   int          dly_q[$];
   logic [16:0] prev_snap;
   logic [16:0] snap_m;
   logic [16:0] exp_m;
   int          dly_m;
   int          ref_m;

   // Hand-derived power-up sequence from OFF (all supplies good).
   logic [3:0] up_st [14] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                              4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8};
   logic [8:0] up_o  [14] = '{O_NONE, O_NONE, O_15, O_15, O_18, O_18, O_RAILS,
                              O_RAILS, O_RAILS, O_CLK, O_CLK, O_RST1, O_RST1, O_ON};
   int         up_d  [14] = '{1, 1, 1, 11, 1, 11, 1, 11, 1, 1, 7, 1, 7, 1};

   pwr_seq_ctrl_if bus ();

   pwr_seq_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .RAIL_DLY  (RAIL_DLY),
      .PGOOD_TMO (PGOOD_TMO),
      .RST_DLY   (RST_DLY),
      .CNT_W     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [16:0] mk(input logic [3:0] st, input logic [8:0] o,
                                      input logic f, input logic [2:0] c);
      return {st, o, f, c};
   endfunction

   function automatic logic [16:0] sample();
      return {bus.state, bus.en_1v5, bus.en_1v8, bus.en_0v95, bus.clk_pwrgd,
              bus.refclk_oe, bus.cpu_reset_n, bus.pex_perst_n, bus.sys_reset_n,
              bus.slot_perst_n, bus.fault, bus.fault_code};
   endfunction

   task automatic ex(input logic [3:0] st, input logic [8:0] o, input logic f,
                     input logic [2:0] c, input int d);
      exp_q.push_back(mk(st, o, f, c));
      dly_q.push_back(d);
   endtask

   task automatic push_up(input int n);
      for (int i = 0; i < n; i++) ex(up_st[i], up_o[i], 1'b0, 3'd0, up_d[i]);
   endtask

   // Drive all inputs just after a rising edge; mark=1 makes this step the
   // timing reference for the next expected change.
   task automatic drive(input logic pr, input logic fc, input logic atx,
                        input logic pm, input logic px, input logic r,
                        input bit mark);
      @(posedge clk);
      #1;
      bus.pwr_req    = pr;
      bus.fault_clr  = fc;
      bus.atx_pgood  = atx;
      bus.pmic_pgood = pm;
      bus.pex_pgood  = px;
      rst            = r;
      if (mark) mark_cyc = cyc;
   endtask

   // Wait (bounded) until every expected change has been seen, then idle a
   // few cycles so any stray change is caught by the monitor.
   task automatic drain(input int maxc, input string nm);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: %0d expected changes still pending", nm, exp_q.size());
         exp_q.delete();
         dly_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   // Monitor: every change of the observed snapshot is one transaction.
   always @(negedge clk) begin
      if (mon_en) begin
         snap_m = sample();
         if (snap_m !== prev_snap) begin
            ref_m = (mark_cyc > last_chg) ? mark_cyc : last_chg;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, snap_m, prev_snap);
            end else begin
               exp_m = exp_q.pop_front();
               dly_m = dly_q.pop_front();
               if (snap_m !== exp_m || (cyc - ref_m) != dly_m) begin
                  errors++;
                  $display("FAIL event cyc=%0d got snap=%h dly=%0d, required snap=%h dly=%0d",
                           cyc, snap_m, cyc - ref_m, exp_m, dly_m);
               end else begin
                  $display("event cyc=%0d state=%0d outs=%b fault=%0d code=%0d dly=%0d ok",
                           cyc, snap_m[16:13], snap_m[12:4], snap_m[3], snap_m[2:0], dly_m);
               end
            end
            prev_snap = snap_m;
            last_chg  = cyc;
         end
      end
   end

   initial begin
      bus.pwr_req    = 1'b0;
      bus.fault_clr  = 1'b0;
      bus.atx_pgood  = 1'b0;
      bus.pmic_pgood = 1'b0;
      bus.pex_pgood  = 1'b0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (sample() !== mk(4'd0, O_NONE, 1'b0, 3'd0)) begin
         errors++;
         $display("FAIL reset_state got=%h required=%h", sample(), mk(4'd0, O_NONE, 1'b0, 3'd0));
      end
      prev_snap = mk(4'd0, O_NONE, 1'b0, 3'd0);
      last_chg  = cyc;
      mark_cyc  = cyc;
      mon_en    = 1'b1;

      // Nominal power-up.
      drive(0, 0, 1, 1, 1, 0, 1);
      push_up(14);
      drive(1, 0, 1, 1, 1, 0, 1);
      drain(300, "power_up");

      // Orderly shutdown from ON.
      ex(4'd9,  O_ON,    0, 3'd0, 1);
      ex(4'd9,  O_RAILS, 0, 3'd0, 1);
      ex(4'd10, O_RAILS, 0, 3'd0, 7);
      ex(4'd10, O_18,    0, 3'd0, 1);
      ex(4'd11, O_18,    0, 3'd0, 11);
      ex(4'd11, O_15,    0, 3'd0, 1);
      ex(4'd12, O_15,    0, 3'd0, 11);
      ex(4'd12, O_NONE,  0, 3'd0, 1);
      ex(4'd0,  O_NONE,  0, 3'd0, 11);
      drive(0, 0, 1, 1, 1, 0, 1);
      drain(300, "shutdown");

      // Power-good timeout.
      drive(0, 0, 1, 0, 0, 0, 1);
      push_up(8);
      ex(4'd15, O_RAILS, 1, 3'd2, 40);
      ex(4'd15, O_NONE,  1, 3'd2, 1);
      drive(1, 0, 1, 0, 0, 0, 1);
      drain(300, "pg_timeout");
      drive(1, 1, 1, 0, 0, 0, 1);
      drive(1, 0, 1, 0, 0, 0, 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (sample() !== mk(4'd15, O_NONE, 1'b1, 3'd2)) begin
         errors++;
         $display("FAIL fault_clr_ignored got=%h required=%h", sample(), mk(4'd15, O_NONE, 1'b1, 3'd2));
      end
      ex(4'd0, O_NONE, 0, 3'd0, 1);
      drive(0, 1, 1, 0, 0, 0, 1);
      drive(0, 0, 1, 0, 0, 0, 0);
      drain(50, "fault_clear_tmo");

      // Power-good loss in ON.
      drive(0, 0, 1, 1, 1, 0, 1);
      push_up(14);
      drive(1, 0, 1, 1, 1, 0, 1);
      drain(300, "power_up2");
      ex(4'd15, O_ON,   1, 3'd3, 1);
      ex(4'd15, O_NONE, 1, 3'd3, 1);
      drive(1, 0, 1, 1, 0, 0, 1);
      drive(1, 0, 1, 1, 1, 0, 0);
      drain(50, "pg_lost");
      ex(4'd0, O_NONE, 0, 3'd0, 1);
      drive(0, 1, 1, 1, 1, 0, 1);
      drive(0, 0, 1, 1, 1, 0, 0);
      drain(50, "fault_clear_pgl");

      // ATX loss and shutdown request in the same cycle: the fault wins.
      push_up(14);
      drive(1, 0, 1, 1, 1, 0, 1);
      drain(300, "power_up3");
      ex(4'd15, O_ON,   1, 3'd1, 1);
      ex(4'd15, O_NONE, 1, 3'd1, 1);
      drive(0, 0, 0, 1, 1, 0, 1);
      drain(50, "atx_vs_req");
      ex(4'd0, O_NONE, 0, 3'd0, 1);
      drive(0, 1, 1, 1, 1, 0, 1);
      drive(0, 0, 1, 1, 1, 0, 0);
      drain(50, "fault_clear_atx");

      // Reset during EN_1V8, then a full restart with pwr_req still high.
      push_up(5);
      drive(1, 0, 1, 1, 1, 0, 1);
      drain(100, "to_en_1v8");
      ex(4'd0, O_NONE, 0, 3'd0, 1);
      push_up(14);
      drive(1, 0, 1, 1, 1, 1, 1);
      drive(1, 0, 1, 1, 1, 0, 0);
      drain(300, "reset_restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
- Board power and reset sequencer. It replaces the software-driven rail, clock and reset bits currently toggled through the general PIO.
- Brings rails 1V5 -> 1V8 -> 0V95 up in order, checks PMIC/PEX power-good, starts the clock generator and reference clocks, then releases the CPU, PCIe switch and slot resets.
- Shuts down in reverse order, and latches a fault on power-good loss or timeout.
- Sits between the top level and the PMIC/clock/reset pins. Top level inverts the en_* outputs onto the DISABLE_* pins.

Parameters:
- TICK_DIV, 100, clk cycles per timer tick (1 us at 100 MHz).
- RAIL_DLY, 1000, ticks dwelt after each rail enable/disable.
- PGOOD_TMO, 50000, ticks allowed for pmic_pgood and pex_pgood to both assert.
- RST_DLY, 2000, ticks between clock-on, first reset release and second reset release.
- CNT_W, 16, tick counter width; must hold max(RAIL_DLY, PGOOD_TMO, RST_DLY).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous to clk, active-high.
- pwr_req  in  1  level request, 1 = power on; already synchronised.
- fault_clr  in  1  single-cycle pulse; clears a latched fault.
- atx_pgood  in  1  ATX supply good.
- pmic_pgood  in  1  PMIC power good.
- pex_pgood  in  1  PCIe switch power good.
- en_1v5  out  1  rail enable, active-high.
- en_1v8  out  1  rail enable, active-high.
- en_0v95  out  1  rail enable, active-high.
- clk_pwrgd  out  1  clock generator power-good.
- refclk_oe  out  1  block/PEX reference clock enable.
- cpu_reset_n  out  1  CPU reset, active-low.
- pex_perst_n  out  1  switch PERST, active-low.
- sys_reset_n  out  1  system reset, active-low.
- slot_perst_n  out  1  slot PERST, active-low.
- state  out  4  current state encoding.
- fault  out  1  latched fault flag.
- fault_code  out  3  latched fault cause.

Behaviour:
- All outputs are registered and decoded from the state register; they change one clk after the state transition.
- Reset (sync, active-high) has priority over everything, including mid-sequence. It forces OFF, with all en_*/clk_pwrgd/refclk_oe = 0, all *_n = 0, fault = 0, fault_code = 0, and the timer cleared.
- Timer: prescaler and tick counter are both cleared on every state entry. A dwell of N ticks therefore lasts exactly N*TICK_DIV clk cycles.
- OFF: outputs as at reset. When pwr_req=1 -> WAIT_ATX.
- WAIT_ATX: when atx_pgood=1 -> EN_1V5. When pwr_req=0 -> OFF. No timeout.
- EN_1V5: en_1v5=1; dwell RAIL_DLY -> EN_1V8.
- EN_1V8: adds en_1v8=1; dwell RAIL_DLY -> EN_0V95.
- EN_0V95: adds en_0v95=1; dwell RAIL_DLY -> WAIT_PG.
- WAIT_PG:
  - when pmic_pgood & pex_pgood both 1 -> CLK_ON;
  - at PGOOD_TMO ticks without both -> FAULT, code 2;
  - if both the pgood condition and the timeout occur in the same cycle, pgood wins.
- CLK_ON: clk_pwrgd=1, refclk_oe=1; dwell RST_DLY -> RST1.
- RST1: cpu_reset_n=1, pex_perst_n=1; dwell RST_DLY -> ON.
- ON: additionally sys_reset_n=1, slot_perst_n=1.
- Supervision, in every state from EN_1V5 through ON:
  - atx_pgood=0 -> FAULT, code 1;
  - in CLK_ON, RST1 and ON, pmic_pgood=0 or pex_pgood=0 -> FAULT, code 3.
- Shutdown request: pwr_req=0 in any state from EN_1V5 through ON -> SD_RST. If a fault condition and pwr_req=0 occur in the same cycle, the fault wins.
- SD_RST: all *_n=0, clk_pwrgd=0, refclk_oe=0; rails unchanged; dwell RST_DLY -> SD_0V95.
- SD_0V95, SD_1V8, SD_1V5: drop en_0v95, then en_1v8, then en_1v5, each followed by a RAIL_DLY dwell. After SD_1V5 -> OFF.
- Rails keep their current values throughout shutdown except the one being dropped.
- pwr_req reasserted during shutdown is ignored until OFF is reached.
- FAULT: all outputs forced off (as reset) on the cycle after entry; fault=1 and fault_code is held.
  - fault_clr=1 with pwr_req=0 -> OFF; fault and fault_code cleared.
  - fault_clr with pwr_req=1 is ignored.
- Fault codes: 0 none, 1 ATX lost, 2 pgood timeout, 3 pgood lost.
- State encoding: OFF=0, WAIT_ATX=1, EN_1V5=2, EN_1V8=3, EN_0V95=4, WAIT_PG=5, CLK_ON=6, RST1=7, ON=8, SD_RST=9, SD_0V95=10, SD_1V8=11, SD_1V5=12, FAULT=15.

Decomposition:
- Package pwr_seq_pkg: state enumeration with the fixed encodings above, and fault code constants.
- Sub-module pwr_seq_timer, parameters TICK_DIV and CNT_W:
  - inputs clk, rst, clr, target[CNT_W];
  - output done, which goes high when target ticks have elapsed since clr;
  - the FSM pulses clr on every state entry.

Test Plan (TICK_DIV=4, RAIL_DLY=3, PGOOD_TMO=10, RST_DLY=2):
- Nominal power-up:
  - stimulus: atx=1, pmic/pex pgood=1, then pwr_req rises;
  - required: en_1v5, en_1v8 and en_0v95 rise 12 clk apart; clk_pwrgd rises in CLK_ON; cpu_reset_n rises 8 clk later; sys_reset_n rises 8 clk after that; state=8.
- Power-good timeout: pgood held 0 through the rail sequence -> 40 clk after WAIT_PG entry, fault=1, fault_code=2, all en_*=0. Then fault_clr with pwr_req=1 -> no change; pwr_req=0 plus fault_clr -> state=0, fault=0.
- Orderly shutdown: in ON, drop pwr_req -> all *_n=0 and clk_pwrgd=0 next cycle; en_0v95 falls after 8 clk, en_1v8 after a further 12, en_1v5 after a further 12; then state=0.
- Power-good loss in ON: pex_pgood=0 for one cycle -> FAULT, code 3; all outputs 0 one cycle after entry.
- Simultaneous events in ON: atx_pgood=0 and pwr_req=0 in the same cycle -> FAULT, code 1, not SD_RST.
- Reset mid-sequence: rst during EN_1V8 -> next cycle state=0, all en_*=0; with pwr_req still 1, the sequence restarts from WAIT_ATX with full dwells.
